// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// Optional feature macro: UART_RX_MAJORITY_VOTE_EN (3-sample majority vote per bit).
package uart_pkg;

   localparam int unsigned PHASE_W    = 4;
   localparam int unsigned PHASE_LAST = 15;
   localparam int unsigned PHASE_MID  = 8;
   localparam int unsigned BYTE_W     = 8;
   localparam int unsigned BITCNT_W   = 4;

`ifdef UART_RX_MAJORITY_VOTE_EN
   // Vote uses phases 7,8,9; the bit is known once phase 9 is sampled.
   localparam int unsigned PHASE_DECIDE = PHASE_MID + 1;
`else
   localparam int unsigned PHASE_DECIDE = PHASE_MID;
`endif

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } rx_state_t;

endpackage

// File: rtl/uart_rx_sampler.sv
// RX synchroniser plus bit decision (single sample or optional 2-of-3 vote).
// Macro: UART_RX_MAJORITY_VOTE_EN enables the vote registers.
// Ports:
//   clk, rst_n    clock, async active-low reset
//   rx            raw serial line
//   tick          16x baud enable
//   phase         current bit phase from the receive FSM
//   rx_sync       synchronised line level
//   bit_val_c     decided bit value (valid with bit_strobe_c)
//   bit_strobe_c  one-cycle pulse at the decision tick
module uart_rx_sampler
   import uart_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               rx,
   input  logic               tick,
   input  logic [PHASE_W-1:0] phase,
   output logic               rx_sync,
   output logic               bit_val_c,
   output logic               bit_strobe_c
);

   logic [SYNC_STAGES-1:0] sync_q;

   // Metastability chain, idles high like the line.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '1;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
      end
   end

   assign rx_sync = sync_q[SYNC_STAGES-1];

`ifdef UART_RX_MAJORITY_VOTE_EN
   logic vote7_q;
   logic vote8_q;

   // Capture the two early samples; the third is the live value at phase 9.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vote7_q <= 1'b1;
         vote8_q <= 1'b1;
      end else if (tick) begin
         if (phase == PHASE_W'(PHASE_MID - 1)) vote7_q <= rx_sync;
         if (phase == PHASE_W'(PHASE_MID))     vote8_q <= rx_sync;
      end
   end

   assign bit_val_c = (vote7_q & vote8_q) | (vote7_q & rx_sync) | (vote8_q & rx_sync);
`else
   assign bit_val_c = rx_sync;
`endif

   assign bit_strobe_c = tick && (phase == PHASE_W'(PHASE_DECIDE));

endmodule

// File: rtl/uart_rx_core.sv
// UART receive engine: oversamples RX on the 16x baud tick, recovers
// start/data/parity/stop bits and hands a byte plus status to the register layer.
// Macro: UART_RX_MAJORITY_VOTE_EN selects 2-of-3 majority bit sampling.
// Ports:
//   CLK, RESET_N     clock, async active-low reset
//   BAUD_CLOCK       16x baud enable pulse
//   RX               serial line (idle high)
//   BIT8, PARITY_EN, ODD_N_EVEN   frame format
//   READ_RX_BYTE     consumer acknowledge pulse
//   RX_DATA, RX_READY, PARITY_ERR, FRAMING_ERR, OVERFLOW   received byte and status
module uart_rx_core
   import uart_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic              CLK,
   input  logic              RESET_N,
   input  logic              BAUD_CLOCK,
   input  logic              RX,
   input  logic              BIT8,
   input  logic              PARITY_EN,
   input  logic              ODD_N_EVEN,
   input  logic              READ_RX_BYTE,
   output logic [BYTE_W-1:0] RX_DATA,
   output logic              RX_READY,
   output logic              PARITY_ERR,
   output logic              FRAMING_ERR,
   output logic              OVERFLOW
);

   rx_state_t           state;
   logic [PHASE_W-1:0]  phase;
   logic [BITCNT_W-1:0] bit_cnt;
   logic [BYTE_W-1:0]   shreg;
   logic                par_err_q;
   logic [BYTE_W-1:0]   frame_data_q;
   logic                frame_perr_q;
   logic                frame_stop_q;
   logic                frame_done_q;

   logic                rx_sync;
   logic                bit_val_c;
   logic                bit_strobe_c;
   logic                wrap_c;
   logic [BITCNT_W-1:0] nbits_c;
   logic [BYTE_W-1:0]   data_c;

   uart_rx_sampler #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sampler (
      .clk          (CLK),
      .rst_n        (RESET_N),
      .rx           (RX),
      .tick         (BAUD_CLOCK),
      .phase        (phase),
      .rx_sync      (rx_sync),
      .bit_val_c    (bit_val_c),
      .bit_strobe_c (bit_strobe_c)
   );

   assign wrap_c  = BAUD_CLOCK && (phase == PHASE_W'(PHASE_LAST));
   assign nbits_c = BIT8 ? BITCNT_W'(8) : BITCNT_W'(7);
   // Bits enter at the MSB, so a 7-bit frame sits one position high.
   assign data_c  = BIT8 ? shreg : {1'b0, shreg[BYTE_W-1:1]};

   // Frame recovery FSM; advances only on baud ticks.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state        <= IDLE;
         phase        <= '0;
         bit_cnt      <= '0;
         shreg        <= '0;
         par_err_q    <= 1'b0;
         frame_data_q <= '0;
         frame_perr_q <= 1'b0;
         frame_stop_q <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         frame_done_q <= 1'b0;
         if (BAUD_CLOCK) begin
            case (state)
               IDLE: begin
                  phase   <= '0;
                  bit_cnt <= '0;
                  if (!rx_sync) state <= START;
               end
               START: begin
                  phase <= phase + PHASE_W'(1);
                  if (bit_strobe_c && bit_val_c) begin
                     state <= IDLE;  // line back high: glitch, not a start bit
                     phase <= '0;
                  end else if (wrap_c) begin
                     state <= DATA;
                  end
               end
               DATA: begin
                  phase <= phase + PHASE_W'(1);
                  if (bit_strobe_c) begin
                     shreg   <= {bit_val_c, shreg[BYTE_W-1:1]};
                     bit_cnt <= bit_cnt + BITCNT_W'(1);
                  end
                  if (wrap_c && (bit_cnt == nbits_c)) begin
                     state <= PARITY_EN ? PARITY : STOP;
                  end
               end
               PARITY: begin
                  phase <= phase + PHASE_W'(1);
                  if (bit_strobe_c) par_err_q <= (^data_c) ^ bit_val_c ^ ODD_N_EVEN;
                  if (wrap_c) state <= STOP;
               end
               STOP: begin
                  phase <= phase + PHASE_W'(1);
                  // Finish at mid-stop so a following start edge is not missed.
                  if (bit_strobe_c) begin
                     frame_data_q <= data_c;
                     frame_perr_q <= PARITY_EN & par_err_q;
                     frame_stop_q <= bit_val_c;
                     frame_done_q <= 1'b1;
                     state        <= IDLE;
                     phase        <= '0;
                  end
               end
               default: begin
                  state <= IDLE;
                  phase <= '0;
               end
            endcase
         end
      end
   end

   // Delivery to the consumer; a completion beats a simultaneous read.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         RX_DATA     <= '0;
         RX_READY    <= 1'b0;
         PARITY_ERR  <= 1'b0;
         FRAMING_ERR <= 1'b0;
         OVERFLOW    <= 1'b0;
      end else if (frame_done_q) begin
         if (!RX_READY || READ_RX_BYTE) begin
            RX_DATA     <= frame_data_q;
            PARITY_ERR  <= frame_perr_q;
            FRAMING_ERR <= ~frame_stop_q;
            RX_READY    <= 1'b1;
            if (READ_RX_BYTE) OVERFLOW <= 1'b0;
         end else begin
            OVERFLOW <= 1'b1;
         end
      end else if (READ_RX_BYTE) begin
         RX_READY <= 1'b0;
         OVERFLOW <= 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core with BAUD_CLOCK tied high (1 bit = 16 CLK).
// Expected frames are queued when sent and compared when RX_READY appears.
module tb_uart_rx_core;

   typedef struct {
      logic [7:0] data;
      logic       perr;
      logic       ferr;
   } exp_t;

   logic       CLK = 1'b0;
   logic       RESET_N;
   logic       BAUD_CLOCK;
   logic       RX;
   logic       BIT8;
   logic       PARITY_EN;
   logic       ODD_N_EVEN;
   logic       READ_RX_BYTE;
   logic [7:0] RX_DATA;
   logic       RX_READY;
   logic       PARITY_ERR;
   logic       FRAMING_ERR;
   logic       OVERFLOW;

   exp_t sb_q[$];
   int   n_pass  = 0;
   int   n_total = 0;

   uart_rx_core dut (
      .CLK          (CLK),
      .RESET_N      (RESET_N),
      .BAUD_CLOCK   (BAUD_CLOCK),
      .RX           (RX),
      .BIT8         (BIT8),
      .PARITY_EN    (PARITY_EN),
      .ODD_N_EVEN   (ODD_N_EVEN),
      .READ_RX_BYTE (READ_RX_BYTE),
      .RX_DATA      (RX_DATA),
      .RX_READY     (RX_READY),
      .PARITY_ERR   (PARITY_ERR),
      .FRAMING_ERR  (FRAMING_ERR),
      .OVERFLOW     (OVERFLOW)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_total = n_total + 1;
      assert (obs === exp) n_pass = n_pass + 1;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic drive_bit(input logic b);
      RX = b;
      repeat (16) @(negedge CLK);
   endtask

   task automatic idle(input int n);
      RX = 1'b1;
      repeat (n) @(negedge CLK);
   endtask

   // Sends one frame; when push is set the expected delivery is queued.
   task automatic send_frame(input logic [7:0] d, input int nbits, input logic par_en,
                             input logic pb, input logic stopb, input logic push);
      exp_t e;
      logic [7:0] dm;
      BIT8      = (nbits == 8);
      PARITY_EN = par_en;
      dm = (nbits == 8) ? d : (d & 8'h7F);
      e.data = dm;
      e.perr = par_en ? ((($countones(dm) + int'(pb)) % 2) != (ODD_N_EVEN ? 1 : 0)) : 1'b0;
      e.ferr = ~stopb;
      if (push) sb_q.push_back(e);
      drive_bit(1'b0);
      for (int i = 0; i < nbits; i++) drive_bit(d[i]);
      if (par_en) drive_bit(pb);
      drive_bit(stopb);
      RX = 1'b1;
   endtask

   task automatic wait_ready(input string tag);
      int n;
      n = 0;
      while (RX_READY !== 1'b1 && n < 400) begin
         @(negedge CLK);
         n++;
      end
      check({tag, "_ready"}, 8'(RX_READY), 8'h01);
   endtask

   task automatic pop_check(input string tag);
      exp_t e;
      if (sb_q.size() == 0) begin
         check({tag, "_sb_nonempty"}, 8'h00, 8'h01);
      end else begin
         e = sb_q.pop_front();
         check({tag, "_data"}, RX_DATA, e.data);
         check({tag, "_perr"}, 8'(PARITY_ERR), 8'(e.perr));
         check({tag, "_ferr"}, 8'(FRAMING_ERR), 8'(e.ferr));
      end
   endtask

   task automatic read_byte();
      READ_RX_BYTE = 1'b1;
      @(negedge CLK);
      READ_RX_BYTE = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_data"}, RX_DATA, 8'h00);
      check({tag, "_ready"}, 8'(RX_READY), 8'h00);
      check({tag, "_perr"}, 8'(PARITY_ERR), 8'h00);
      check({tag, "_ferr"}, 8'(FRAMING_ERR), 8'h00);
      check({tag, "_ovf"}, 8'(OVERFLOW), 8'h00);
   endtask

   initial begin
      RESET_N      = 1'b0;
      BAUD_CLOCK   = 1'b1;
      RX           = 1'b1;
      BIT8         = 1'b1;
      PARITY_EN    = 1'b0;
      ODD_N_EVEN   = 1'b0;
      READ_RX_BYTE = 1'b0;
      repeat (3) @(negedge CLK);
      check_all_zero("reset");
      RESET_N = 1'b1;
      idle(10);

      // 8N1 0xA5
      send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, 1'b1);
      wait_ready("a5");
      pop_check("a5");
      check("a5_ovf", 8'(OVERFLOW), 8'h00);
      read_byte();
      check("a5_read_ready", 8'(RX_READY), 8'h00);
      idle(8);

      // 8E1 0x3C with bad then good parity bit
      ODD_N_EVEN = 1'b0;
      send_frame(8'h3C, 8, 1'b1, 1'b1, 1'b1, 1'b1);
      wait_ready("3c_e_bad");
      pop_check("3c_e_bad");
      read_byte();
      idle(8);
      send_frame(8'h3C, 8, 1'b1, 1'b0, 1'b1, 1'b1);
      wait_ready("3c_e_ok");
      pop_check("3c_e_ok");
      read_byte();
      idle(8);

      // 8O1 0x3C with parity bit 1 is correct
      ODD_N_EVEN = 1'b1;
      send_frame(8'h3C, 8, 1'b1, 1'b1, 1'b1, 1'b1);
      wait_ready("3c_o_ok");
      pop_check("3c_o_ok");
      read_byte();
      ODD_N_EVEN = 1'b0;
      idle(8);

      // Short low glitch must be rejected
      BIT8 = 1'b1;
      PARITY_EN = 1'b0;
      RX = 1'b0;
      repeat (4) @(negedge CLK);
      idle(40);
      check("glitch_ready", 8'(RX_READY), 8'h00);
      check("glitch_ferr", 8'(FRAMING_ERR), 8'h00);
      send_frame(8'h55, 8, 1'b0, 1'b0, 1'b1, 1'b1);
      wait_ready("55");
      pop_check("55");
      read_byte();
      idle(8);

      // Stop bit 0: still delivered with FRAMING_ERR
      send_frame(8'h81, 8, 1'b0, 1'b0, 1'b0, 1'b1);
      wait_ready("81_fe");
      pop_check("81_fe");
      read_byte();
      idle(40);
      check("81_fe_no_spurious", 8'(RX_READY), 8'h00);

      // Back-to-back frames without read: second one overflows
      send_frame(8'h11, 8, 1'b0, 1'b0, 1'b1, 1'b1);
      send_frame(8'h22, 8, 1'b0, 1'b0, 1'b1, 1'b0);
      idle(8);
      wait_ready("ovf");
      pop_check("ovf");
      check("ovf_flag", 8'(OVERFLOW), 8'h01);
      read_byte();
      check("ovf_read_ready", 8'(RX_READY), 8'h00);
      check("ovf_read_flag", 8'(OVERFLOW), 8'h00);
      idle(8);

      // Leave a byte pending, then reset mid-frame during data bit 3
      send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1, 1'b1);
      wait_ready("5a");
      pop_check("5a");
      idle(8);
      drive_bit(1'b0);
      drive_bit(1'b1);
      drive_bit(1'b1);
      drive_bit(1'b1);
      RX = 1'b0;
      repeat (8) @(negedge CLK);
      RESET_N = 1'b0;
      #1;
      check_all_zero("midreset");
      @(negedge CLK);
      RX = 1'b1;
      repeat (4) @(negedge CLK);
      RESET_N = 1'b1;
      idle(20);
      check("midreset_after_ready", 8'(RX_READY), 8'h00);

      // 7N1 0x7F after reset
      send_frame(8'h7F, 7, 1'b0, 1'b0, 1'b1, 1'b1);
      wait_ready("7f");
      pop_check("7f");
      read_byte();
      idle(8);

      check("sb_empty", 8'(sb_q.size()), 8'h00);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
